// File: rtl/rggen_axi4lite_bridge_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rggen_bus_if : register bus between the AXI4-Lite bridge and splitter    |
// | direction: 1 = write, 0 = read; status: 00 OKAY, 10 SLVERR, 11 DECERR    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface rggen_bus_if #(
  parameter int ADDRESS_WIDTH = 16,
  parameter int DATA_WIDTH    = 32
);
  logic                      request;
  logic [ADDRESS_WIDTH-1:0]  address;
  logic                      direction;
  logic [DATA_WIDTH-1:0]     write_data;
  logic [DATA_WIDTH/8-1:0]   write_strobe;
  logic                      done;
  logic                      write_done;
  logic                      read_done;
  logic [DATA_WIDTH-1:0]     read_data;
  logic [1:0]                status;

  modport master (
    output request, address, direction, write_data, write_strobe,
    input  done, write_done, read_done, read_data, status
  );

  modport slave (
    input  request, address, direction, write_data, write_strobe,
    output done, write_done, read_done, read_data, status
  );
endinterface
`default_nettype wire

// File: rtl/rggen_axi4lite_bridge.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rggen_axi4lite_bridge : AXI4-Lite slave to rggen_bus_if, one access at a |
// | time. Define RGGEN_AXI4LITE_WRITE_PRIORITY_EN for fixed write priority.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module rggen_axi4lite_bridge #(
  parameter int ADDRESS_WIDTH = 16,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     awvalid,
  output logic                     awready,
  input  logic [ADDRESS_WIDTH-1:0] awaddr,
  input  logic [2:0]               awprot,
  input  logic                     wvalid,
  output logic                     wready,
  input  logic [DATA_WIDTH-1:0]    wdata,
  input  logic [DATA_WIDTH/8-1:0]  wstrb,
  output logic                     bvalid,
  input  logic                     bready,
  output logic [1:0]               bresp,
  input  logic                     arvalid,
  output logic                     arready,
  input  logic [ADDRESS_WIDTH-1:0] araddr,
  input  logic [2:0]               arprot,
  output logic                     rvalid,
  input  logic                     rready,
  output logic [DATA_WIDTH-1:0]    rdata,
  output logic [1:0]               rresp,
  rggen_bus_if.master              bus_if
);
  localparam int         STRB_WIDTH   = DATA_WIDTH / 8;
  localparam logic [1:0] IDLE         = 2'd0;
  localparam logic [1:0] ACCESS       = 2'd1;
  localparam logic [1:0] RESPONSE     = 2'd2;
  localparam logic       RGGEN_READ   = 1'b0;
  localparam logic       RGGEN_WRITE  = 1'b1;
  localparam logic [1:0] AXI_OKAY     = 2'b00;
  localparam logic [1:0] AXI_SLVERR   = 2'b10;
  localparam logic [1:0] AXI_DECERR   = 2'b11;

  logic [1:0]               state_q, state_d;
  logic                     ready_en_q, ready_en_d;
  logic                     aw_full_q, aw_full_d;
  logic [ADDRESS_WIDTH-1:0] aw_addr_q, aw_addr_d;
  logic                     w_full_q, w_full_d;
  logic [DATA_WIDTH-1:0]    w_data_q, w_data_d;
  logic [STRB_WIDTH-1:0]    w_strb_q, w_strb_d;
  logic                     request_q, request_d;
  logic [ADDRESS_WIDTH-1:0] address_q, address_d;
  logic                     direction_q, direction_d;
  logic [DATA_WIDTH-1:0]    write_data_q, write_data_d;
  logic [STRB_WIDTH-1:0]    write_strobe_q, write_strobe_d;
  logic [1:0]               resp_q, resp_d;
  logic [DATA_WIDTH-1:0]    rdata_q, rdata_d;
  logic                     write_pend, read_pend, grant_write, grant_read;
  logic [1:0]               axi_status;
  logic                     unused_inputs;
`ifndef RGGEN_AXI4LITE_WRITE_PRIORITY_EN
  logic                     last_write_q, last_write_d;
`endif

  assign unused_inputs = ^{awprot, arprot, bus_if.read_done, bus_if.write_done};

  always_comb begin
    write_pend = aw_full_q && w_full_q;
    read_pend  = ready_en_q && arvalid;
`ifdef RGGEN_AXI4LITE_WRITE_PRIORITY_EN
    grant_write = (state_q == IDLE) && write_pend;
    grant_read  = (state_q == IDLE) && read_pend && !write_pend;
`else
    // On a tie the type that did not win last time is granted
    grant_write = (state_q == IDLE) && write_pend && (!read_pend || !last_write_q);
    grant_read  = (state_q == IDLE) && read_pend && (!write_pend || last_write_q);
`endif
  end

  always_comb begin
    case (bus_if.status)
      2'b10:   axi_status = AXI_SLVERR;
      2'b11:   axi_status = AXI_DECERR;
      default: axi_status = AXI_OKAY;
    endcase
  end

  // ready_en keeps every ready low until the first edge after reset release
  assign awready = ready_en_q && !aw_full_q;
  assign wready  = ready_en_q && !w_full_q;
  assign arready = grant_read;
  assign bvalid  = (state_q == RESPONSE) && (direction_q == RGGEN_WRITE);
  assign rvalid  = (state_q == RESPONSE) && (direction_q == RGGEN_READ);
  assign bresp   = (direction_q == RGGEN_WRITE) ? resp_q : 2'b00;
  assign rresp   = (direction_q == RGGEN_READ)  ? resp_q : 2'b00;
  assign rdata   = rdata_q;

  assign bus_if.request      = request_q;
  assign bus_if.address      = address_q;
  assign bus_if.direction    = direction_q;
  assign bus_if.write_data   = write_data_q;
  assign bus_if.write_strobe = write_strobe_q;

  always_comb begin
    state_d        = state_q;
    ready_en_d     = 1'b1;
    aw_full_d      = aw_full_q;
    aw_addr_d      = aw_addr_q;
    w_full_d       = w_full_q;
    w_data_d       = w_data_q;
    w_strb_d       = w_strb_q;
    request_d      = request_q;
    address_d      = address_q;
    direction_d    = direction_q;
    write_data_d   = write_data_q;
    write_strobe_d = write_strobe_q;
    resp_d         = resp_q;
    rdata_d        = rdata_q;
`ifndef RGGEN_AXI4LITE_WRITE_PRIORITY_EN
    last_write_d   = last_write_q;
    if (grant_write)     last_write_d = 1'b1;
    else if (grant_read) last_write_d = 1'b0;
`endif

    if (awvalid && awready) begin
      aw_full_d = 1'b1;
      aw_addr_d = awaddr;
    end
    if (wvalid && wready) begin
      w_full_d = 1'b1;
      w_data_d = wdata;
      w_strb_d = wstrb;
    end

    case (state_q)
      IDLE: begin
        if (grant_write) begin
          request_d      = 1'b1;
          address_d      = aw_addr_q;
          direction_d    = RGGEN_WRITE;
          write_data_d   = w_data_q;
          write_strobe_d = w_strb_q;
          aw_full_d      = 1'b0;
          w_full_d       = 1'b0;
          state_d        = ACCESS;
        end else if (grant_read) begin
          request_d      = 1'b1;
          address_d      = araddr;
          direction_d    = RGGEN_READ;
          write_data_d   = '0;
          write_strobe_d = '0;
          state_d        = ACCESS;
        end
      end
      ACCESS: begin
        if (bus_if.done) begin
          request_d = 1'b0;
          resp_d    = axi_status;
          rdata_d   = (direction_q == RGGEN_WRITE) ? '0 : bus_if.read_data;
          state_d   = RESPONSE;
        end
      end
      RESPONSE: begin
        if ((direction_q == RGGEN_WRITE && bready) || (direction_q == RGGEN_READ && rready))
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      ready_en_q     <= 1'b0;
      aw_full_q      <= 1'b0;
      aw_addr_q      <= '0;
      w_full_q       <= 1'b0;
      w_data_q       <= '0;
      w_strb_q       <= '0;
      request_q      <= 1'b0;
      address_q      <= '0;
      direction_q    <= RGGEN_READ;
      write_data_q   <= '0;
      write_strobe_q <= '0;
      resp_q         <= 2'b00;
      rdata_q        <= '0;
`ifndef RGGEN_AXI4LITE_WRITE_PRIORITY_EN
      last_write_q   <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      ready_en_q     <= ready_en_d;
      aw_full_q      <= aw_full_d;
      aw_addr_q      <= aw_addr_d;
      w_full_q       <= w_full_d;
      w_data_q       <= w_data_d;
      w_strb_q       <= w_strb_d;
      request_q      <= request_d;
      address_q      <= address_d;
      direction_q    <= direction_d;
      write_data_q   <= write_data_d;
      write_strobe_q <= write_strobe_d;
      resp_q         <= resp_d;
      rdata_q        <= rdata_d;
`ifndef RGGEN_AXI4LITE_WRITE_PRIORITY_EN
      last_write_q   <= last_write_d;
`endif
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_rggen_axi4lite_bridge.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_rggen_axi4lite_bridge : directed scoreboard bench with splitter model |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_rggen_axi4lite_bridge;
  localparam logic DIR_R = 1'b0;
  localparam logic DIR_W = 1'b1;

  typedef struct packed {
    logic        dir;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [1:0]  resp;
    logic [31:0] rdata;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        awvalid = 0, wvalid = 0, arvalid = 0, bready = 1, rready = 1;
  logic        awready, wready, arready, bvalid, rvalid;
  logic [15:0] awaddr = 0, araddr = 0;
  logic [31:0] wdata = 0, rdata;
  logic [3:0]  wstrb = 0;
  logic [1:0]  bresp, rresp;

  int          n_cmp = 0;
  int          n_err = 0;
  int          sp_wait = 0;
  int          lat_cnt = 0;
  logic [1:0]  sp_status = 2'b00;
  logic [31:0] sp_rdata = 32'h0;
  logic        req_prev = 1'b0;
  int          req_pulses = 0;
  int          ar_hs = 0;
  txn_t        exp_q[$];
  txn_t        bus_q[$];
  txn_t        rsp_q[$];

  always #5 clk = ~clk;

  rggen_bus_if #(.ADDRESS_WIDTH(16), .DATA_WIDTH(32)) bus_if ();

  rggen_axi4lite_bridge #(.ADDRESS_WIDTH(16), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awprot(3'b000),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arprot(3'b000),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
    .bus_if(bus_if)
  );

  function automatic txn_t mk(input logic d, input logic [15:0] a, input logic [31:0] wd,
                              input logic [3:0] s, input logic [1:0] r, input logic [31:0] rd);
    mk = {d, a, wd, s, r, rd};
  endfunction

  // Splitter model plus handshake monitors
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_if.done       <= 1'b0;
      bus_if.read_done  <= 1'b0;
      bus_if.write_done <= 1'b0;
      bus_if.read_data  <= 32'h0;
      bus_if.status     <= 2'b00;
      lat_cnt           <= 0;
      req_prev          <= 1'b0;
    end else begin
      req_prev <= bus_if.request;
      if (bus_if.request && !req_prev) req_pulses <= req_pulses + 1;
      if (arvalid && arready) ar_hs <= ar_hs + 1;
      if (bvalid && bready) rsp_q.push_back(mk(DIR_W, 16'h0, 32'h0, 4'h0, bresp, rdata));
      if (rvalid && rready) rsp_q.push_back(mk(DIR_R, 16'h0, 32'h0, 4'h0, rresp, rdata));
      if (bus_if.done) begin
        bus_if.done       <= 1'b0;
        bus_if.read_done  <= 1'b0;
        bus_if.write_done <= 1'b0;
      end else if (bus_if.request) begin
        if (lat_cnt < sp_wait) begin
          lat_cnt <= lat_cnt + 1;
        end else begin
          lat_cnt           <= 0;
          bus_if.done       <= 1'b1;
          bus_if.read_done  <= (bus_if.direction == DIR_R);
          bus_if.write_done <= (bus_if.direction == DIR_W);
          bus_if.read_data  <= sp_rdata;
          bus_if.status     <= sp_status;
          bus_q.push_back(mk(bus_if.direction, bus_if.address, bus_if.write_data,
                             bus_if.write_strobe, 2'b00, 32'h0));
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_aw(input logic [15:0] a);
    bit ok = 1'b0;
    awaddr = a; awvalid = 1'b1;
    for (int i = 0; i < 100 && !ok; i++) begin
      #1; ok = awready;
      @(posedge clk); @(negedge clk);
    end
    awvalid = 1'b0;
    chk("aw_handshake", ok, 1);
  endtask

  task automatic drive_w(input logic [31:0] d, input logic [3:0] s);
    bit ok = 1'b0;
    wdata = d; wstrb = s; wvalid = 1'b1;
    for (int i = 0; i < 100 && !ok; i++) begin
      #1; ok = wready;
      @(posedge clk); @(negedge clk);
    end
    wvalid = 1'b0;
    chk("w_handshake", ok, 1);
  endtask

  task automatic drive_ar(input logic [15:0] a);
    bit ok = 1'b0;
    araddr = a; arvalid = 1'b1;
    for (int i = 0; i < 100 && !ok; i++) begin
      #1; ok = arready;
      @(posedge clk); @(negedge clk);
    end
    arvalid = 1'b0;
    chk("ar_handshake", ok, 1);
  endtask

  task automatic wait_rsp(input int n, input string tag);
    for (int i = 0; i < 200 && rsp_q.size() < n; i++) @(negedge clk);
    chk({tag, "_rsp_timeout"}, rsp_q.size() >= n, 1);
  endtask

  task automatic check_txn(input string tag);
    txn_t e, b, r;
    chk({tag, "_avail"}, {exp_q.size() > 0, bus_q.size() > 0, rsp_q.size() > 0}, 3'b111);
    if (exp_q.size() == 0 || bus_q.size() == 0 || rsp_q.size() == 0) return;
    e = exp_q.pop_front(); b = bus_q.pop_front(); r = rsp_q.pop_front();
    chk({tag, "_bus_dir"},   b.dir,   e.dir);
    chk({tag, "_bus_addr"},  b.addr,  e.addr);
    chk({tag, "_bus_wdata"}, b.wdata, e.wdata);
    chk({tag, "_bus_strb"},  b.strb,  e.strb);
    chk({tag, "_rsp_dir"},   r.dir,   e.dir);
    chk({tag, "_rsp_resp"},  r.resp,  e.resp);
    chk({tag, "_rsp_rdata"}, r.rdata, e.rdata);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ctl"}, {awready, wready, arready, bvalid, rvalid, bus_if.request, bresp, rresp}, 0);
    chk({tag, "_rdata"}, rdata, 0);
    chk({tag, "_bus_fields"}, {bus_if.address, bus_if.write_strobe}, 0);
    chk({tag, "_bus_wdata"}, bus_if.write_data, 0);
  endtask

  initial begin
    int p0, a0;
    bit seen;

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Single write; read_data from splitter must not leak into rdata
    sp_rdata = 32'hCAFEF00D;
    p0 = req_pulses;
    exp_q.push_back(mk(DIR_W, 16'h0010, 32'hDEADBEEF, 4'hF, 2'b00, 32'h0));
    fork
      drive_aw(16'h0010);
      drive_w(32'hDEADBEEF, 4'hF);
    join
    wait_rsp(1, "wr1");
    check_txn("wr1");
    chk("wr1_req_pulses", req_pulses - p0, 1);
    chk("wr1_bvalid_drop", bvalid, 0);

    // Single read
    sp_rdata = 32'h12345678;
    p0 = req_pulses; a0 = ar_hs;
    exp_q.push_back(mk(DIR_R, 16'h0004, 32'h0, 4'h0, 2'b00, 32'h12345678));
    drive_ar(16'h0004);
    wait_rsp(1, "rd1");
    check_txn("rd1");
    chk("rd1_arready_pulses", ar_hs - a0, 1);
    chk("rd1_req_pulses", req_pulses - p0, 1);
    chk("rd1_rvalid_drop", rvalid, 0);

    // W ahead of AW by 3 cycles, decode error returned
    sp_status = 2'b11;
    p0 = req_pulses;
    drive_w(32'hA5A55A5A, 4'b0101);
    for (int i = 0; i < 3; i++) begin
      chk("dec_w_held", {wready, bus_if.request}, 2'b00);
      @(negedge clk);
    end
    chk("dec_no_req", req_pulses - p0, 0);
    exp_q.push_back(mk(DIR_W, 16'h0018, 32'hA5A55A5A, 4'b0101, 2'b11, 32'h0));
    drive_aw(16'h0018);
    wait_rsp(1, "dec");
    check_txn("dec");
    sp_status = 2'b00;

    // Slave error on read with R backpressure
    sp_status = 2'b10; sp_rdata = 32'h0BADF00D; rready = 1'b0;
    exp_q.push_back(mk(DIR_R, 16'h0020, 32'h0, 4'h0, 2'b10, 32'h0BADF00D));
    drive_ar(16'h0020);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk); seen = rvalid;
    end
    chk("bp_rvalid_rise", seen, 1);
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold", {rvalid, rresp, bus_if.request, bvalid}, 5'b11000);
      @(negedge clk);
    end
    rready = 1'b1;
    wait_rsp(1, "bp");
    check_txn("bp");
    sp_status = 2'b00;

    // Contention: R0 occupies the bus while W1/R1 queue up, then W2/R2
    sp_wait = 1; sp_rdata = 32'h55AA00FF;
    exp_q.push_back(mk(DIR_R, 16'h0040, 32'h0, 4'h0, 2'b00, 32'h55AA00FF));
    exp_q.push_back(mk(DIR_W, 16'h0050, 32'h11112222, 4'hF, 2'b00, 32'h0));
`ifdef RGGEN_AXI4LITE_WRITE_PRIORITY_EN
    exp_q.push_back(mk(DIR_W, 16'h0054, 32'h33334444, 4'h3, 2'b00, 32'h0));
    exp_q.push_back(mk(DIR_R, 16'h0044, 32'h0, 4'h0, 2'b00, 32'h55AA00FF));
`else
    exp_q.push_back(mk(DIR_R, 16'h0044, 32'h0, 4'h0, 2'b00, 32'h55AA00FF));
    exp_q.push_back(mk(DIR_W, 16'h0054, 32'h33334444, 4'h3, 2'b00, 32'h0));
`endif
    exp_q.push_back(mk(DIR_R, 16'h0048, 32'h0, 4'h0, 2'b00, 32'h55AA00FF));
    fork
      begin
        drive_ar(16'h0040);
        drive_ar(16'h0044);
        drive_ar(16'h0048);
      end
      begin
        fork
          drive_aw(16'h0050);
          drive_w(32'h11112222, 4'hF);
        join
        fork
          drive_aw(16'h0054);
          drive_w(32'h33334444, 4'h3);
        join
      end
    join
    wait_rsp(5, "arb");
    for (int i = 0; i < 5; i++) check_txn($sformatf("arb%0d", i));

    // Reset while the splitter is still holding off done
    sp_wait = 6;
    fork
      drive_aw(16'h0060);
      drive_w(32'h0F0F0F0F, 4'hF);
    join
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk); seen = bus_if.request;
    end
    chk("rst_req_seen", seen, 1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_access");
    @(negedge clk);
    rst_n = 1'b1;
    sp_wait = 0;
    repeat (12) @(negedge clk);
    chk("rst_no_response", {rsp_q.size() == 0, bus_q.size() == 0, bvalid, rvalid}, 4'b1100);

    sp_rdata = 32'h600DCAFE;
    exp_q.push_back(mk(DIR_R, 16'h0008, 32'h0, 4'h0, 2'b00, 32'h600DCAFE));
    drive_ar(16'h0008);
    wait_rsp(1, "post_rst");
    check_txn("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire
